product_accumulator: RTL
========================

# product_accumulator

Sequential accumulation stage directly downstream of the two-bit multiplier. It accepts one 4-bit product per handshake and adds it into a saturating running sum. After a programmed number of products it raises `done` and holds the result until cleared. It turns the combinational multiplier into a small multiply-accumulate datapath for dot-product style lab exercises.

## Interface
- `COUNT`, default 4: number of products per batch; legal range 1..15.
- `ACC_W`, default 8: accumulator width in bits; legal range 4..16.

- `clk`  in  1  system clock, rising-edge active.
- `rst`  in  1  asynchronous, active-high reset.
- `p`  in  4  product from the multiplier; legal values 0..9.
- `in_valid`  in  1  `p` is valid this cycle.
- `in_ready`  out  1  block can accept a product this cycle.
- `clear`  in  1  synchronous clear of the sum, count and flags; starts a new batch.
- `acc`  out  ACC_W  running sum, registered.
- `count`  out  4  products accepted in the current batch, registered.
- `done`  out  1  batch complete; `acc` is final.
- `overflow`  out  1  sticky; saturation occurred in the current batch.

One clock. Reset is asynchronous and active-high; ports are named `clk` and `rst`.

## Operation
- **Reset values:**
  - `acc` = 0, `count` = 0, `done` = 0, `overflow` = 0.
  - State = ACCUM, so `in_ready` = 1.
- **States:** ACCUM and HOLD. `in_ready` = 1 in ACCUM and 0 in HOLD. `done` = 1 exactly in HOLD.
- **Accept:** a product is accepted on a rising edge where `in_ready` & `in_valid` & !`clear`.
- **On accept:**
  - `count` ← `count` + 1.
  - `acc` ← `acc` + `p`, computed at ACC_W+1 bits.
  - If the sum exceeds 2^ACC_W − 1, `acc` ← 2^ACC_W − 1 and `overflow` ← 1.
  - Once `acc` has saturated it stays at maximum; later adds keep it there.
- **ACCUM → HOLD:** on an accept where `count` == COUNT−1 before the edge. After that edge `count` == COUNT and `done` = 1.
- **In HOLD:**
  - `in_valid` is ignored and no state changes.
  - `acc`, `count` and `overflow` are held.
- **`clear`**, effective in either state on a rising edge:
  - `acc` ← 0, `count` ← 0, `overflow` ← 0, state ← ACCUM.
  - `clear` has priority over a simultaneous `in_valid`; that product is dropped and not accepted.
- **`p` > 9:** accumulated as-is, with no checking. The multiplier never produces such values.
- **COUNT = 1:** the first accept moves the block to HOLD.

## Timing
- All outputs are registered except `in_ready` and `done`, which decode directly from the state register. Nothing is combinational from inputs to outputs.
- **Latency:** a product accepted at edge N is reflected in `acc` and `count` after edge N.
- **`done`:** asserts in the cycle following the edge that accepted the COUNT-th product. It stays high until the edge on which `clear` is sampled high.
- **Throughput:** one product per cycle in ACCUM; back-to-back `in_valid` is legal.
- **Upstream:** must hold `p` stable while `in_valid` is high and `in_ready` is low. The block does not require `in_valid` to drop.
- **Reset mid-batch:** asynchronous return to the reset values on `rst` assertion, independent of `clk`. The first accept occurs at the first rising edge after `rst` deasserts.
- **`clear` in ACCUM with `in_valid` high:** no accept that cycle; `in_ready` stays 1 and the next cycle accepts normally.

## Test plan
- **Normal batch, defaults:** reset, then products 4, 6, 9, 9 on consecutive cycles with `in_valid` = 1 → `acc` = 28, `count` = 4, `done` = 1 in the following cycle, `overflow` = 0. A fifth `in_valid` with p = 9 leaves `acc` at 28.
- **Saturation (ACC_W = 5, COUNT = 4):** products 9, 9, 9, 9 → `acc` steps 9, 18, 27, 31, `overflow` = 1 at the fourth accept, `done` = 1. Then `clear` → `acc` = 0, `overflow` = 0, `in_ready` = 1.
- **Gapped input:** defaults, p = 2 with `in_valid` toggling 1, 0, 1, 0, 1, 0, 1 → exactly 4 accepts, `acc` = 8, `done` asserted one cycle after the last accept.
- **Clear priority:** after 2 accepts of p = 3 (`acc` = 6), assert `clear` and `in_valid` with p = 9 in the same cycle → `acc` = 0 and `count` = 0 next cycle. Four further accepts of p = 1 → `acc` = 4, `done` = 1.
- **Async reset mid-batch:** after 3 accepts of p = 6, pulse `rst` between clock edges → all outputs return to reset values immediately, without waiting for a `clk` edge.
- **COUNT = 1:** a single accept of p = 6 → `acc` = 6, `done` = 1, `in_ready` = 0 next cycle.

Source files
------------

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - saturating multiply-accumulate stage behind the two-bit multiplier
//
// Accepts one 4-bit product per valid/ready handshake and adds it into a
// saturating running sum. After COUNT products it parks in HOLD with done
// high until clear starts a new batch.
//
// Parameters:
//   COUNT     products per batch (1..15)
//   ACC_W     accumulator width in bits (4..16)
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   p         product from the multiplier (nominally 0..9)
//   in_valid  p is valid this cycle
//   in_ready  block can accept a product (state decode)
//   clear     synchronous clear of sum, count and flags; wins over in_valid
//   acc       running saturating sum (registered)
//   count     products accepted in the current batch (registered)
//   done      batch complete, acc is final (state decode)
//   overflow  sticky saturation flag for the current batch (registered)
module product_accumulator #(
  parameter int COUNT = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       p,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] acc,
  output logic [3:0]       count,
  output logic             done,
  output logic             overflow
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  localparam logic [ACC_W-1:0] ACC_MAX   = {ACC_W{1'b1}};
  localparam logic [3:0]       LAST_IDX  = 4'(COUNT - 1);

  logic [0:0]     state;
  logic           accept;
  logic [ACC_W:0] sum;
  logic           sat;

  assign in_ready = (state == ST_ACCUM);
  assign done     = (state == ST_HOLD);

  // clear has priority: a product offered in the same cycle is dropped.
  assign accept = in_ready & in_valid & ~clear;

  // One extra bit catches the carry out; a saturated acc plus any nonzero
  // product carries again, so saturation is naturally sticky.
  assign sum = {1'b0, acc} + (ACC_W + 1)'(p);
  assign sat = sum[ACC_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_ACCUM;
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      state    <= ST_ACCUM;
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      count <= count + 4'd1;
      if (sat) begin
        acc      <= ACC_MAX;
        overflow <= 1'b1;
      end else begin
        acc <= sum[ACC_W-1:0];
      end
      if (count == LAST_IDX) begin
        state <= ST_HOLD;
      end
    end
  end

endmodule
